mem_host_responder: RTL and testbench
=====================================

// Module: mem_host_responder
// PURPOSE
//  Memory-controller end of the 512-bit cache-line host port used by the fetch/data mem_system caches.
//  Accepts line read/write requests (op_host, AddrOut_host, DataOut_host) and answers with DataIn_host,
//  rd_valid_host, tx_done_host. Splits each line into BEAT_W beats on an Avalon-style backend memory port.
// PARAMETERS
//  LINE_W  512  cache-line width in bits (host side)
//  BEAT_W  64   backend data width in bits; BEATS = LINE_W/BEAT_W (localparam, must divide evenly)
//  ADDR_W  32   byte-address width, host and backend
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       asynchronous, active-low reset
//  op_host        in   2       00 IDLE, 01 READ, 10 WRITE, 11 reserved
//  AddrOut_host   in   ADDR_W  line byte address; bits [log2(LINE_W/8)-1:0] ignored (line aligned)
//  DataOut_host   in   LINE_W  write line
//  DataIn_host    out  LINE_W  read line, valid while rd_valid_host=1
//  rd_valid_host  out  1       one-cycle pulse, read data valid
//  tx_done_host   out  1       one-cycle pulse, request complete
//  mem_addr       out  ADDR_W  backend beat byte address
//  mem_rd         out  1       backend read command
//  mem_wr         out  1       backend write command
//  mem_wdata      out  BEAT_W  backend write beat
//  mem_wait       in   1       backend waitrequest; command accepted on a cycle with mem_rd|mem_wr=1 and mem_wait=0
//  mem_rdata      in   BEAT_W  backend read beat
//  mem_rvalid     in   1       read beat valid; beats return in issue order
// BEHAVIOUR
//  - Reset: all outputs 0, counters 0, state IDLE. Reset mid-transaction abandons it; no tx_done issued.
//  - All outputs registered. States: IDLE, READ, WRITE, RESP, HOLD.
//  - IDLE: on op_host!=00, latch line-aligned address, write line, and op; go READ (01) / WRITE (10) / RESP (11).
//  - Host holds op/addr/data stable until tx_done_host; the latched copies are authoritative after the IDLE cycle.
//  - READ: issue_cnt, rcv_cnt (0..BEATS). mem_rd=1 while issue_cnt<BEATS; mem_addr = base + issue_cnt*(BEAT_W/8).
//    issue_cnt++ on each accepted command. On mem_rvalid, mem_rdata -> line[rcv_cnt*BEAT_W +: BEAT_W], rcv_cnt++.
//    Issue and receive overlap. Enter RESP the cycle after rcv_cnt reaches BEATS.
//  - WRITE: mem_wr=1, mem_wdata = line[issue_cnt*BEAT_W +: BEAT_W], same address rule. Enter RESP after BEATS accepts.
//  - mem_wait=1 holds mem_addr/mem_wdata/mem_rd/mem_wr unchanged; issue_cnt does not advance.
//  - RESP (1 cycle): tx_done_host=1; rd_valid_host=1 with DataIn_host=line only for READ.
//    Op 11 gets tx_done with rd_valid=0 and no backend access. Then HOLD.
//  - HOLD: wait for op_host==00, then IDLE. Back-to-back requests need one idle-op cycle.
//  - DataIn_host keeps its last value outside RESP.
//  - mem_rvalid outside READ, or with rcv_cnt==BEATS, is ignored.
//  - Address arithmetic is modulo 2^ADDR_W; a line at the top of the space wraps.
//  - Latency, zero-wait memory with 1-cycle read return, op seen at cycle 0:
//    READ: mem_rd cycles 1..BEATS; tx_done/rd_valid at cycle BEATS+3.
//    WRITE: mem_wr cycles 1..BEATS; tx_done at cycle BEATS+2.
// STRUCTURE
//  - mem_host_pkg: host_op_t enum (OP_IDLE/OP_READ/OP_WRITE/OP_RSVD); resp_state_t enum; LINE_W/BEAT_W defaults.
//  - Single module. No sub-module: the beat-select mux/demux is inline indexed part-selects.
// TESTING
//  - READ 0x0600_2040, zero-wait memory returning addr-as-data -> mem_rd addrs 0x0600_2040..0x0600_2078 step 8;
//    DataIn_host beat i = 0x0600_2040+8i; rd_valid and tx_done together for exactly 1 cycle.
//  - WRITE 0x0000_1000, DataOut beat i = 0xA0+i, mem_wait=1 on every 2nd cycle -> 8 mem_wr in order, data 0xA0..0xA7;
//    mem_addr/mem_wdata stable under wait; one tx_done; rd_valid stays 0.
//  - READ 0x0600_207F -> low 6 bits ignored, first mem_addr = 0x0600_2040.
//  - READ with rvalid delayed 5 cycles after each command -> correct beat order; tx_done only after the 8th beat.
//  - Op 11 -> tx_done pulse within 2 cycles; no mem_rd/mem_wr; op held after done -> no second response until op=00.
//  - rst_n low after 3 read beats, then READ 0x40 -> outputs 0 during reset; stale rvalids ignored; fresh line correct.

Source files
------------

// File: rtl/mem_host_pkg.sv
// Shared types and defaults for the cache-line host port responder.
// Op codes match the 2-bit op_host encoding driven by the mem_system caches.
package mem_host_pkg;

   localparam int LINE_W_DEF = 512;
   localparam int BEAT_W_DEF = 64;
   localparam int ADDR_W_DEF = 32;

   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10,
      OP_RSVD  = 2'b11
   } host_op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_RESP,
      ST_HOLD
   } resp_state_t;

endpackage

// File: rtl/mem_host_responder.sv
// Memory-controller end of the cache-line host port: splits each line
// request into BEAT_W beats on an Avalon-style backend port.
module mem_host_responder
   import mem_host_pkg::*;
#(
   parameter int LINE_W = LINE_W_DEF,
   parameter int BEAT_W = BEAT_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        op_host,
   input  logic [ADDR_W-1:0] AddrOut_host,
   input  logic [LINE_W-1:0] DataOut_host,
   output logic [LINE_W-1:0] DataIn_host,
   output logic              rd_valid_host,
   output logic              tx_done_host,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [BEAT_W-1:0] mem_wdata,
   input  logic              mem_wait,
   input  logic [BEAT_W-1:0] mem_rdata,
   input  logic              mem_rvalid
);

   localparam int BEATS  = LINE_W / BEAT_W;
   localparam int CNT_W  = $clog2(BEATS + 1);
   localparam int IDX_W  = $clog2(BEATS);
   localparam int BOFF   = $clog2(BEAT_W / 8);
   localparam int LINE_B = LINE_W / 8;
   localparam logic [CNT_W-1:0]  BEATS_C   = CNT_W'(BEATS);
   localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_B - 1);

   resp_state_t                   r_state, w_state;
   logic [ADDR_W-1:0]             r_base, w_base;
   logic [BEATS-1:0][BEAT_W-1:0]  r_line, w_line;
   logic [CNT_W-1:0]              r_issue, w_issue;
   logic [CNT_W-1:0]              r_rcv, w_rcv;
   logic [ADDR_W-1:0]             r_mem_addr, w_mem_addr;
   logic                          r_mem_rd, w_mem_rd;
   logic                          r_mem_wr, w_mem_wr;
   logic [BEAT_W-1:0]             r_mem_wdata, w_mem_wdata;
   logic [LINE_W-1:0]             r_data_in, w_data_in;
   logic                          r_rd_valid, w_rd_valid;
   logic                          r_tx_done, w_tx_done;

   logic                          w_accept;
   logic [CNT_W-1:0]              w_issue_inc;
   logic [ADDR_W-1:0]             w_host_base;
   logic [ADDR_W-1:0]             w_next_addr;

   assign w_accept    = (r_mem_rd | r_mem_wr) & ~mem_wait;
   assign w_issue_inc = r_issue + 1'b1;
   assign w_host_base = AddrOut_host & ~LINE_MASK;
   assign w_next_addr = r_base + (ADDR_W'(w_issue_inc) << BOFF);

   always_comb begin
      w_state     = r_state;
      w_base      = r_base;
      w_line      = r_line;
      w_issue     = r_issue;
      w_rcv       = r_rcv;
      w_mem_addr  = r_mem_addr;
      w_mem_rd    = r_mem_rd;
      w_mem_wr    = r_mem_wr;
      w_mem_wdata = r_mem_wdata;
      w_data_in   = r_data_in;
      w_rd_valid  = 1'b0;
      w_tx_done   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (host_op_t'(op_host) != OP_IDLE) begin
               w_base  = w_host_base;
               w_line  = DataOut_host;
               w_issue = '0;
               w_rcv   = '0;
               case (host_op_t'(op_host))
                  OP_READ: begin
                     w_state    = ST_READ;
                     w_mem_rd   = 1'b1;
                     w_mem_addr = w_host_base;
                  end
                  OP_WRITE: begin
                     w_state     = ST_WRITE;
                     w_mem_wr    = 1'b1;
                     w_mem_addr  = w_host_base;
                     w_mem_wdata = DataOut_host[BEAT_W-1:0];
                  end
                  default: begin
                     w_state   = ST_RESP;
                     w_tx_done = 1'b1;
                  end
               endcase
            end
         end

         ST_READ: begin
            if (w_accept) begin
               w_issue = w_issue_inc;
               if (w_issue_inc < BEATS_C) w_mem_addr = w_next_addr;
               else                       w_mem_rd   = 1'b0;
            end
            // Beats come back in issue order, so rcv_cnt is the slot index.
            if (mem_rvalid && (r_rcv != BEATS_C)) begin
               w_line[r_rcv[IDX_W-1:0]] = mem_rdata;
               w_rcv = r_rcv + 1'b1;
            end
            if (r_rcv == BEATS_C) begin
               w_state    = ST_RESP;
               w_tx_done  = 1'b1;
               w_rd_valid = 1'b1;
               w_data_in  = r_line;
            end
         end

         ST_WRITE: begin
            if (w_accept) begin
               w_issue = w_issue_inc;
               if (w_issue_inc < BEATS_C) begin
                  w_mem_addr  = w_next_addr;
                  w_mem_wdata = r_line[w_issue_inc[IDX_W-1:0]];
               end else begin
                  w_mem_wr = 1'b0;
               end
            end
            if (r_issue == BEATS_C) begin
               w_state   = ST_RESP;
               w_tx_done = 1'b1;
            end
         end

         ST_RESP: w_state = ST_HOLD;

         ST_HOLD: begin
            if (host_op_t'(op_host) == OP_IDLE) w_state = ST_IDLE;
         end

         default: w_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_base      <= '0;
         r_line      <= '0;
         r_issue     <= '0;
         r_rcv       <= '0;
         r_mem_addr  <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_wdata <= '0;
         r_data_in   <= '0;
         r_rd_valid  <= 1'b0;
         r_tx_done   <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_base      <= w_base;
         r_line      <= w_line;
         r_issue     <= w_issue;
         r_rcv       <= w_rcv;
         r_mem_addr  <= w_mem_addr;
         r_mem_rd    <= w_mem_rd;
         r_mem_wr    <= w_mem_wr;
         r_mem_wdata <= w_mem_wdata;
         r_data_in   <= w_data_in;
         r_rd_valid  <= w_rd_valid;
         r_tx_done   <= w_tx_done;
      end
   end

   assign DataIn_host   = r_data_in;
   assign rd_valid_host = r_rd_valid;
   assign tx_done_host  = r_tx_done;
   assign mem_addr      = r_mem_addr;
   assign mem_rd        = r_mem_rd;
   assign mem_wr        = r_mem_wr;
   assign mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_mem_host_responder.sv
// Randomized bench for mem_host_responder with a behavioural backend memory
// and a line-level expectation model.
module tb_mem_host_responder;

   localparam int BEATS = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   op_host = 2'b00;
   logic [31:0]  AddrOut_host = '0;
   logic [511:0] DataOut_host = '0;
   logic [511:0] DataIn_host;
   logic         rd_valid_host, tx_done_host;
   logic [31:0]  mem_addr;
   logic         mem_rd, mem_wr;
   logic [63:0]  mem_wdata;
   logic         mem_wait = 1'b0;
   logic [63:0]  mem_rdata = '0;
   logic         mem_rvalid = 1'b0;

   mem_host_responder dut (
      .clk(clk), .rst_n(rst_n), .op_host(op_host),
      .AddrOut_host(AddrOut_host), .DataOut_host(DataOut_host),
      .DataIn_host(DataIn_host), .rd_valid_host(rd_valid_host),
      .tx_done_host(tx_done_host), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_wait(mem_wait), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   int          wait_mode = 0;
   int          rdelay = 1;
   logic [31:0] salt = '0;
   int          pend_due[$];
   logic [63:0] pend_dat[$];
   logic [31:0] log_addr[$];
   logic [63:0] log_dat[$];
   logic        log_wr[$];
   int          n_done, n_rv, n_beats, done_cyc;
   logic [511:0] rv_line;
   logic [511:0] last_line = '0;
   logic        p_hold = 1'b0;
   logic [31:0] p_addr;
   logic [63:0] p_wdata;
   logic        p_rd, p_wr;

   task automatic chk(input string tag, input logic [511:0] got,
                      input logic [511:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {salt, a};
   endfunction

   task automatic clear_mon();
      log_addr.delete();
      log_dat.delete();
      log_wr.delete();
      n_done = 0;
      n_rv = 0;
      n_beats = 0;
      done_cyc = -1;
   endtask

   // One clock: observe DUT outputs, then drive the backend memory model.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (p_hold) begin
         chk("hold_addr", mem_addr, p_addr);
         chk("hold_wdata", mem_wdata, p_wdata);
         chk("hold_cmd", {mem_rd, mem_wr}, {p_rd, p_wr});
      end
      if (tx_done_host) begin
         n_done++;
         done_cyc = cyc;
      end
      if (rd_valid_host) begin
         n_rv++;
         rv_line = DataIn_host;
         chk("rv_with_done", tx_done_host, 1'b1);
      end
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
         mem_rvalid = 1'b1;
         mem_rdata  = pend_dat[0];
         void'(pend_due.pop_front());
         void'(pend_dat.pop_front());
         n_beats++;
      end
      case (wait_mode)
         1:       mem_wait = (cyc % 2 == 1);
         2:       mem_wait = ($urandom_range(0, 3) == 0);
         default: mem_wait = 1'b0;
      endcase
      p_hold  = (mem_rd | mem_wr) & mem_wait;
      p_addr  = mem_addr;
      p_wdata = mem_wdata;
      p_rd    = mem_rd;
      p_wr    = mem_wr;
      if ((mem_rd | mem_wr) && !mem_wait) begin
         log_addr.push_back(mem_addr);
         log_dat.push_back(mem_wdata);
         log_wr.push_back(mem_wr);
         if (mem_rd) begin
            pend_due.push_back(cyc + rdelay);
            pend_dat.push_back(mem_word(mem_addr));
         end
      end
   endtask

   task automatic run_txn(input logic [1:0] op, input logic [31:0] addr,
                          input logic [511:0] data, input int wm,
                          input int dly, input int exp_lat);
      logic [31:0]  base;
      logic [31:0]  ea;
      logic [511:0] exp_line;
      int t0, budget, n_exp;
      wait_mode = wm;
      rdelay = dly;
      clear_mon();
      op_host = op;
      AddrOut_host = addr;
      DataOut_host = data;
      t0 = cyc;
      budget = 0;
      while (n_done == 0 && budget < 300) begin
         step();
         budget++;
      end
      repeat (4) step();
      op_host = 2'b00;
      repeat (2) step();

      base  = addr & ~32'h3F;
      n_exp = (op == 2'b01 || op == 2'b10) ? BEATS : 0;
      chk("n_done", n_done, 1);
      chk("n_cmd", log_addr.size(), n_exp);
      for (int i = 0; i < n_exp && i < log_addr.size(); i++) begin
         ea = base + 32'(8 * i);
         chk("cmd_addr", log_addr[i], ea);
         chk("cmd_is_wr", log_wr[i], op == 2'b10);
         if (op == 2'b10) chk("cmd_wdata", log_dat[i], data[i*64 +: 64]);
      end
      chk("n_rv", n_rv, op == 2'b01);
      if (op == 2'b01) begin
         for (int i = 0; i < BEATS; i++)
            exp_line[i*64 +: 64] = mem_word(base + 32'(8 * i));
         chk("rd_line", rv_line, exp_line);
         last_line = exp_line;
      end
      if (op == 2'b11) chk("rsvd_lat_le2", (done_cyc - t0) <= 2, 1'b1);
      if (exp_lat >= 0) chk("latency", done_cyc - t0, exp_lat);
      chk("datain_keep", DataIn_host, last_line);
   endtask

   initial begin
      logic [511:0] d;
      logic [1:0]   rop;
      int           budget;
      clear_mon();

      repeat (3) step();
      chk("rst_rd", mem_rd, 1'b0);
      chk("rst_wr", mem_wr, 1'b0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_done", tx_done_host, 1'b0);
      chk("rst_rv", rd_valid_host, 1'b0);
      chk("rst_din", DataIn_host, 512'h0);
      rst_n = 1'b1;
      repeat (2) step();

      salt = 32'h0;
      run_txn(2'b01, 32'h0600_2040, 512'h0, 0, 1, BEATS + 3);

      for (int i = 0; i < BEATS; i++) d[i*64 +: 64] = 64'(32'hA0 + i);
      run_txn(2'b10, 32'h0000_1000, d, 1, 1, -1);

      run_txn(2'b01, 32'h0600_207F, 512'h0, 0, 1, BEATS + 3);

      salt = 32'h5A5A_0001;
      run_txn(2'b01, 32'h1234_5680, 512'h0, 0, 5, -1);

      run_txn(2'b11, 32'h0000_0040, 512'h0, 0, 1, -1);

      for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
      run_txn(2'b10, 32'h8000_0000, d, 0, 1, BEATS + 2);

      run_txn(2'b01, 32'hFFFF_FFC0, 512'h0, 2, 3, -1);

      // Abort a read after three beats; stale returns must not leak.
      salt = 32'hDEAD_0000;
      wait_mode = 0;
      rdelay = 3;
      clear_mon();
      op_host = 2'b01;
      AddrOut_host = 32'h0600_2040;
      budget = 0;
      while (n_beats < 3 && budget < 100) begin
         step();
         budget++;
      end
      chk("beats_before_rst", n_beats, 3);
      rst_n = 1'b0;
      op_host = 2'b00;
      #1;
      chk("arst_rd", mem_rd, 1'b0);
      chk("arst_addr", mem_addr, 32'h0);
      chk("arst_din", DataIn_host, 512'h0);
      step();
      chk("rst_mid_rd", mem_rd, 1'b0);
      chk("rst_mid_done", tx_done_host, 1'b0);
      step();
      rst_n = 1'b1;
      last_line = '0;
      repeat (8) step();
      chk("no_done_after_rst", n_done, 0);
      chk("pend_drained", pend_due.size(), 0);
      salt = 32'h0BAD_F00D;
      run_txn(2'b01, 32'h0000_0040, 512'h0, 0, 1, BEATS + 3);

      for (int t = 0; t < 40; t++) begin
         rop  = 2'($urandom_range(1, 3));
         salt = $urandom;
         for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
         run_txn(rop, $urandom, d, $urandom_range(0, 2),
                 $urandom_range(1, 6), -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
